// File: rtl/c_elastic_pipe_stage.sv
// Elastic pipeline stage: one main entry plus one skid entry, valid/ready handshake,
// legacy stall/flush controls and saturating stall/flush performance counters.
module c_elastic_pipe_stage #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    logic             r_main_v;
    logic [WIDTH-1:0] r_main_d;
    logic             r_skid_v;
    logic [WIDTH-1:0] r_skid_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_main_v_d;
    logic [WIDTH-1:0] w_main_d_d;
    logic             w_skid_v_d;
    logic [WIDTH-1:0] w_skid_d_d;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] w_flush_cnt_d;

    occ_e w_occ;
    logic w_accept;
    logic w_emit;
    logic w_stall_inc;
    logic w_flush_inc;

    // skid_v implies main_v, so the pair maps directly onto occupancy
    always_comb begin
        w_occ = StEmpty;
        if (r_skid_v) begin
            w_occ = StFull;
        end else if (r_main_v) begin
            w_occ = StOne;
        end
    end

    assign occupancy = w_occ;
    assign in_ready  = !stall && !flush && (w_occ != StFull);
    assign out_valid = r_main_v && !stall && !flush;
    assign out_data  = r_main_d;
    assign w_accept  = in_valid && in_ready;
    assign w_emit    = out_valid && out_ready;

    always_comb begin
        w_main_v_d = r_main_v;
        w_main_d_d = r_main_d;
        w_skid_v_d = r_skid_v;
        w_skid_d_d = r_skid_d;
        if (flush) begin
            w_main_v_d = 1'b0;
            w_main_d_d = NOP_VALUE;
            w_skid_v_d = 1'b0;
            w_skid_d_d = NOP_VALUE;
        end else if (!stall) begin
            unique case (w_occ)
                StEmpty: begin
                    if (w_accept) begin
                        w_main_v_d = 1'b1;
                        w_main_d_d = in_data;
                    end
                end
                StOne: begin
                    if (w_accept && w_emit) begin
                        w_main_d_d = in_data;
                    end else if (w_accept) begin
                        w_skid_v_d = 1'b1;
                        w_skid_d_d = in_data;
                    end else if (w_emit) begin
                        w_main_v_d = 1'b0;
                        w_main_d_d = NOP_VALUE;
                    end
                end
                StFull: begin
                    if (w_emit) begin
                        w_main_d_d = r_skid_d;
                        w_skid_v_d = 1'b0;
                        w_skid_d_d = NOP_VALUE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_stall_inc = r_main_v && !flush && (stall || !out_ready);
    assign w_flush_inc = flush && r_main_v;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt;
        w_flush_cnt_d = r_flush_cnt;
        if (cnt_clr) begin
            w_stall_cnt_d = '0;
            w_flush_cnt_d = '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                w_stall_cnt_d = r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                w_flush_cnt_d = r_flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_v    <= 1'b0;
            r_main_d    <= NOP_VALUE;
            r_skid_v    <= 1'b0;
            r_skid_d    <= NOP_VALUE;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_main_v    <= w_main_v_d;
            r_main_d    <= w_main_d_d;
            r_skid_v    <= w_skid_v_d;
            r_skid_d    <= w_skid_d_d;
            r_stall_cnt <= w_stall_cnt_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_c_elastic_pipe_stage.sv
// Directed bench for c_elastic_pipe_stage: a scoreboard queue tracks accepted payloads,
// plus a CNT_W=2 instance for counter saturation.
module tb_c_elastic_pipe_stage;

    localparam logic [15:0] Nop = 16'h0013;

    logic        clk = 1'b0;
    logic        reset_n;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] q[$];

    // Instance A: WIDTH=16, CNT_W=16
    logic        in_valid, in_ready, out_valid, out_ready, stall, flush, cnt_clr;
    logic [15:0] in_data, out_data, stall_cnt, flush_cnt;
    logic [1:0]  occupancy;

    // Instance B: CNT_W=2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_occupancy, b_stall_cnt, b_flush_cnt;

    always #5 clk = ~clk;

    c_elastic_pipe_stage #(.WIDTH(16), .NOP_VALUE(Nop), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    c_elastic_pipe_stage #(.WIDTH(16), .NOP_VALUE(Nop), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall(1'b0), .flush(1'b0), .cnt_clr(b_cnt_clr),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes seen at negedge complete on the following rising edge
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("emit_unexpected", {16'h0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("order", {16'h0, out_data}, {16'h0, q.pop_front()});
                    end
                end
                if (in_valid && in_ready) q.push_back(in_data);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        {in_valid, out_ready, stall, flush, cnt_clr} = '0;
        in_data = '0;
        {b_in_valid, b_out_ready, b_cnt_clr} = '0;
        b_in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", {30'h0, occupancy}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_data", {16'h0, out_data}, {16'h0, Nop});
        chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);

        // Streaming 0x0001..0x0010 with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_data = 16'(k);
            @(negedge clk);
            if (k > 1) begin
                chk("stream_lat", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'(k - 1)});
                chk("stream_occ", {30'h0, occupancy}, 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0010});
        tick();
        @(negedge clk);
        chk("stream_empty", {14'h0, occupancy, out_data}, {14'h0, 2'd0, Nop});
        chk("stream_stall_cnt", {16'h0, stall_cnt}, 32'd0);

        // Backpressure: A then B fill the stage
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00AA;
        tick();
        in_data   = 16'h00BB;
        tick();
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_occ", {30'h0, occupancy}, 32'd2);
        chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
        chk("bp_head", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h00AA});
        tick();
        chk("bp_stall_cnt", {16'h0, stall_cnt}, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_full", {31'h0, in_ready}, 32'd0);
        tick();
        chk("bp_second", {14'h0, in_ready, out_valid, out_data}, {14'h0, 2'b11, 16'h00BB});
        tick();
        chk("bp_drained", {14'h0, occupancy, stall_cnt}, {14'h0, 2'd0, 16'd2});

        // Flush while FULL with C on the input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0031;
        tick();
        in_data   = 16'h0032;
        tick();
        in_data   = 16'h00CC;
        flush     = 1'b1;
        #1;
        chk("fl_mask", {30'h0, in_ready, out_valid}, 32'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("fl_state", {13'h0, occupancy, out_valid, out_data}, {13'h0, 2'd0, 1'b0, Nop});
        chk("fl_cnt", {16'h0, flush_cnt}, 32'd1);
        chk("fl_stall_cnt", {16'h0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_emit", {31'h0, out_valid}, 32'd0);

        // Stall together with flush while ONE: flush wins
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0044;
        tick();
        in_valid  = 1'b0;
        stall     = 1'b1;
        flush     = 1'b1;
        tick();
        stall     = 1'b0;
        flush     = 1'b0;
        chk("sf_occ", {30'h0, occupancy}, 32'd0);
        chk("sf_cnts", {stall_cnt, flush_cnt}, {16'd3, 16'd2});

        // Stall alone for three cycles while ONE
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        tick();
        in_valid  = 1'b0;
        stall     = 1'b1;
        #1;
        chk("st_mask", {30'h0, in_ready, out_valid}, 32'd0);
        repeat (3) tick();
        chk("st_hold", {13'h0, occupancy, out_valid, out_data}, {13'h0, 2'd1, 1'b0, 16'h0055});
        chk("st_cnt", {16'h0, stall_cnt}, 32'd6);
        stall     = 1'b0;
        #1;
        chk("st_release", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0055});
        tick();
        chk("st_empty", {30'h0, occupancy}, 32'd0);

        // Saturation on the CNT_W=2 instance
        b_in_valid = 1'b1;
        b_in_data  = 16'h0001;
        tick();
        b_in_valid = 1'b0;
        repeat (6) tick();
        chk("sat_cnt", {30'h0, b_stall_cnt}, 32'd3);
        b_cnt_clr  = 1'b1;
        tick();
        b_cnt_clr  = 1'b0;
        chk("sat_clr", {30'h0, b_stall_cnt}, 32'd0);
        tick();
        chk("sat_resume", {30'h0, b_stall_cnt}, 32'd1);
        chk("sat_occ", {30'h0, b_occupancy}, 32'd1);

        // Asynchronous reset mid-FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0071;
        tick();
        in_data   = 16'h0072;
        tick();
        in_valid  = 1'b0;
        chk("ar_full", {30'h0, occupancy}, 32'd2);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("ar_occ", {30'h0, occupancy}, 32'd0);
        chk("ar_out", {15'h0, out_valid, out_data}, {15'h0, 1'b0, Nop});
        chk("ar_cnts", {stall_cnt, flush_cnt}, 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("ar_in_ready", {31'h0, in_ready}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0099;
        tick();
        in_valid  = 1'b0;
        chk("ar_fresh", {15'h0, out_valid, out_data}, {15'h0, 1'b1, 16'h0099});
        tick();
        tick();
        chk("sb_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
